spi_reg_bank: RTL and testbench

- System-clock-domain SPI slave and register bank that replaces the free-running SPI-clocked latch.
- Oversamples SCLK/CS/MOSI on the crystal clock and decodes 16-bit frames (command byte + data byte).
- Writes NREG 8-bit control registers that drive LEDs and downstream peripheral controls, and returns register contents on MISO.
- A frame commits only when exactly 16 bits were clocked while CS was low. Short, long and aborted frames are discarded.

---
 rtl/spi_reg_bank.sv | 135 +++++++++++++
 tb/tb_spi_reg_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: clk-domain SPI slave (sample on sclk fall, drive on rise) with an NREG x 8-bit register bank.
module spi_reg_bank #(
  parameter int NREG        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [NREG*8-1:0] reg_out,
  output logic              wr_stb,
  output logic [6:0]        wr_addr,
  output logic              frame_err
);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, CMD, DATA} state_t;
  state_t                        state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0]   sync_q, sync_d;
  logic [2:0]                    hist_q, hist_d;
  logic [4:0]                    cnt_q, cnt_d, cnt_inc;
  logic [7:0]                    rx_q, rx_d, rx_shift;
  logic [7:0]                    tx_q, tx_d, rd_byte;
  logic                          rw_q, rw_d;
  logic [6:0]                    addr_q, addr_d;
  logic                          miso_q, miso_d;
  logic [NREG*8-1:0]             regs_q, regs_d;
  logic                          wr_stb_q, wr_stb_d;
  logic [6:0]                    wr_addr_q, wr_addr_d;
  logic                          frame_err_q, frame_err_d;
  logic                          sclk_s, cs_s, mosi_s, sclk_fall, sclk_rise, cs_fall, cs_rise;
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sclk, cs, mosi};
    hist_d    = sync_q[SYNC_STAGES-1];
    sclk_s    = hist_d[2];
    cs_s      = hist_d[1];
    mosi_s    = hist_q[0];
    sclk_fall = hist_q[2] & ~sclk_s;
    sclk_rise = ~hist_q[2] & sclk_s;
    cs_fall   = hist_q[1] & ~cs_s;
    cs_rise   = ~hist_q[1] & cs_s;
    rx_shift  = {rx_q[6:0], mosi_s};
    cnt_inc   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
    rd_byte   = 8'h00;
    for (int i = 0; i < NREG; i++)
      if (rx_shift[6:0] == 7'(i)) rd_byte = regs_q[i*8 +: 8];
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    if (state_q == WAIT_IDLE) begin
      if (cs_s) state_d = IDLE;
    end else if (cs_rise) begin
      // cs rise outranks any sclk edge seen in the same cycle
      state_d = IDLE;
      miso_d  = 1'b0;
      if (cnt_q != 5'd16) frame_err_d = 1'b1;
      else if (!rw_q)
        for (int i = 0; i < NREG; i++)
          if (addr_q == 7'(i)) begin
            regs_d[i*8 +: 8] = rx_q;
            wr_stb_d         = 1'b1;
            wr_addr_d        = addr_q;
          end
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        cnt_d   = 5'd0;
        rx_d    = 8'h00;
        tx_d    = 8'h00;
        miso_d  = 1'b0;
        state_d = CMD;
      end
    end else begin
      if (sclk_fall) begin
        rx_d  = rx_shift;
        cnt_d = cnt_inc;
        if (state_q == CMD && cnt_inc == 5'd8) begin
          rw_d    = rx_shift[7];
          addr_d  = rx_shift[6:0];
          tx_d    = rx_shift[7] ? rd_byte : 8'h00;
          state_d = DATA;
        end
      end
      if (sclk_rise && state_q == DATA) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      hist_q      <= '0;
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      regs_q      <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign miso      = miso_q;
  assign miso_oe   = ~cs_s;
  assign reg_out   = regs_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames at sclk = clk/8 with hand-computed register and MISO expectations.
module tb_spi_reg_bank;
  logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe, wr_stb, frame_err;
  logic [31:0] reg_out;
  logic [6:0]  wr_addr;
  logic [15:0] miso_bits = '0;
  logic        oe_mid = 1'b0;
  int          checks = 0, errors = 0, stb_cnt = 0, err_cnt = 0;

  spi_reg_bank #(.NREG(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .reg_out(reg_out), .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) stb_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b1;
      mosi = v[i];
      repeat (4) @(negedge clk);
      if (i < 16) miso_bits[i] = miso;
      oe_mid = miso_oe;
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(v, n);
    cs = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (reg_out !== 32'h0) begin errors++; $display("FAIL reset_reg_out got %h exp %h", reg_out, 32'h0); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb got %b exp 0", wr_stb); end
    checks++; if (wr_addr !== 7'h0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL idle_miso_oe got %b exp 0", miso_oe); end
  endtask

  task automatic test_write();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    frame(32'h01A5, 16);
    checks++; if (oe_mid !== 1'b1) begin errors++; $display("FAIL frame_miso_oe got %b exp 1", oe_mid); end
    repeat (2) @(posedge clk); #1;
    checks++; if (reg_out !== 32'h0) begin errors++; $display("FAIL write_early got %h exp %h", reg_out, 32'h0); end
    @(posedge clk); #1;
    checks++; if (reg_out !== 32'h0000A500) begin errors++; $display("FAIL write_reg_out got %h exp %h", reg_out, 32'h0000A500); end
    checks++; if (wr_stb !== 1'b1) begin errors++; $display("FAIL write_stb_hi got %b exp 1", wr_stb); end
    checks++; if (wr_addr !== 7'd1) begin errors++; $display("FAIL write_addr got %h exp 1", wr_addr); end
    @(posedge clk); #1;
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL write_stb_lo got %b exp 0", wr_stb); end
    settle();
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL write_stb_count got %0d exp 1", stb_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL write_err_count got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_read();
    int s0;
    frame(32'h003C, 16);
    settle();
    s0 = stb_cnt;
    frame(32'h8000, 16);
    settle();
    checks++; if (miso_bits[7:0] !== 8'h3C) begin errors++; $display("FAIL read_data got %h exp %h", miso_bits[7:0], 8'h3C); end
    checks++; if (miso_bits[15:8] !== 8'h00) begin errors++; $display("FAIL read_cmd_phase got %h exp 00", miso_bits[15:8]); end
    checks++; if (reg_out !== 32'h0000A53C) begin errors++; $display("FAIL read_reg_out got %h exp %h", reg_out, 32'h0000A53C); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL read_stb_count got %0d exp 0", stb_cnt - s0); end
  endtask

  task automatic test_short_long();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    frame(32'h0155, 15);
    settle();
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL short_err got %0d exp 1", err_cnt - e0); end
    checks++; if (reg_out[23:16] !== 8'h00) begin errors++; $display("FAIL short_reg2 got %h exp 00", reg_out[23:16]); end
    frame(32'h0555, 17);
    settle();
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL long_err got %0d exp 2", err_cnt - e0); end
    checks++; if (reg_out !== 32'h0000A53C) begin errors++; $display("FAIL long_reg_out got %h exp %h", reg_out, 32'h0000A53C); end
    frame(32'h0, 0);
    settle();
    checks++; if (err_cnt - e0 !== 3) begin errors++; $display("FAIL empty_err got %0d exp 3", err_cnt - e0); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL discard_stb got %0d exp 0", stb_cnt - s0); end
  endtask

  task automatic test_out_of_range();
    int s0, e0;
    frame(32'h035A, 16);
    settle();
    s0 = stb_cnt; e0 = err_cnt;
    frame(32'h0577, 16);
    settle();
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL oor_write_stb got %0d exp 0", stb_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL oor_write_err got %0d exp 0", err_cnt - e0); end
    checks++; if (reg_out !== 32'h5A00A53C) begin errors++; $display("FAIL oor_reg_out got %h exp %h", reg_out, 32'h5A00A53C); end
    frame(32'hFF00, 16);
    settle();
    checks++; if (miso_bits[7:0] !== 8'h00) begin errors++; $display("FAIL oor_read_data got %h exp 00", miso_bits[7:0]); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL oor_read_err got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'h0, 6);
    rst_n = 1'b0;
    #1;
    checks++; if (reg_out !== 32'h0) begin errors++; $display("FAIL midrst_clear got %h exp 0", reg_out); end
    @(negedge clk);
    rst_n = 1'b1;
    shift_bits(32'h155, 10);
    cs = 1'b1;
    settle();
    checks++; if (reg_out !== 32'h0) begin errors++; $display("FAIL midrst_no_write got %h exp 0", reg_out); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL midrst_stb got %0d exp 0", stb_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_err got %0d exp 0", err_cnt - e0); end
    frame(32'h03FF, 16);
    settle();
    checks++; if (reg_out !== 32'hFF000000) begin errors++; $display("FAIL midrst_next got %h exp %h", reg_out, 32'hFF000000); end
    checks++; if (wr_addr !== 7'd3) begin errors++; $display("FAIL midrst_addr got %h exp 3", wr_addr); end
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL midrst_next_stb got %0d exp 1", stb_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    int s0, e0;
    test_reset();
    s0 = stb_cnt; e0 = err_cnt;
    frame(32'h0011, 16);
    repeat (2) @(negedge clk);
    frame(32'h0222, 16);
    settle();
    checks++; if (stb_cnt - s0 !== 2) begin errors++; $display("FAIL b2b_stb got %0d exp 2", stb_cnt - s0); end
    checks++; if (reg_out !== 32'h00220011) begin errors++; $display("FAIL b2b_reg_out got %h exp %h", reg_out, 32'h00220011); end
    checks++; if (wr_addr !== 7'd2) begin errors++; $display("FAIL b2b_addr got %h exp 2", wr_addr); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_err got %0d exp 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_short_long();
    test_out_of_range();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
